// File: rtl/nfc_sched_pkg.sv
// Shared types and constants for the NAND page-copy scheduler and its copy engine.
package nfc_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN
  } sched_state_t;

  localparam int DEF_PAGE_W = 9;
  localparam int DEF_CNT_W  = 10;

  // Command bytes the copy engine sequences for an internal copy-back operation.
  localparam logic [7:0] NAND_CMD_READ        = 8'h00;
  localparam logic [7:0] NAND_CMD_COPYBACK_RD = 8'h35;
  localparam logic [7:0] NAND_CMD_COPYBACK_PG = 8'h85;
  localparam logic [7:0] NAND_CMD_PROG_CFM    = 8'h10;
  localparam logic [7:0] NAND_CMD_READ_STATUS = 8'h70;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nfc_rr_arb.sv
// Combinational round-robin pick: first requesting index at or after rr_ptr, wrapping cyclically.
module nfc_rr_arb
  import nfc_sched_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = idx_width(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (int'(rr_ptr) + k) % NREQ;
      if (!any && req[j]) begin
        any       = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/nfc_copy_scheduler.sv
// Shares one page-copy engine between NREQ job requesters, one page per grant in round-robin order,
// with a per-page watchdog that aborts a job whose engine never reports done.
module nfc_copy_scheduler
  import nfc_sched_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int PAGE_W = DEF_PAGE_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int TMO_W  = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*PAGE_W-1:0]   req_page,
  input  logic [NREQ*CNT_W-1:0]    req_npages,
  output logic [NREQ-1:0]          cpl_valid,
  output logic [NREQ-1:0]          cpl_err,
  output logic                     eng_start,
  output logic [PAGE_W-1:0]        eng_page,
  input  logic                     eng_busy,
  input  logic                     eng_done,
  output logic                     idle
);

  localparam int IDX_W = idx_width(NREQ);
  // Expiry is flagged on the last of the 2^TMO_W-1 waiting cycles.
  localparam logic [TMO_W-1:0] TMO_LAST = ~TMO_W'(1);

  sched_state_t      state;
  logic [IDX_W-1:0]  sel;
  logic [NREQ-1:0]   sel_oh;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  next_ptr;
  logic [TMO_W-1:0]  wdog;

  logic [NREQ-1:0]   ctx_active;
  logic [PAGE_W-1:0] ctx_page [NREQ];
  logic [NREQ-1:0]   step_oh;
  logic [NREQ-1:0]   abort_oh;
  logic [NREQ-1:0]   arb_req;
  logic [NREQ-1:0]   grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_any;

  assign req_ready = ~ctx_active;
  assign idle      = ~|ctx_active && (state == S_IDLE) && !eng_busy;
  assign next_ptr  = (sel == IDX_W'(NREQ - 1)) ? '0 : sel + IDX_W'(1);
  assign step_oh   = (state == S_WAIT && eng_done) ? sel_oh : '0;
  assign abort_oh  = (state == S_WAIT && !eng_done && wdog == TMO_LAST) ? sel_oh : '0;

  // A context stays active through its completion pulse, so it must be masked out of arbitration then.
  assign arb_req   = ctx_active & ~cpl_valid;

  nfc_rr_arb #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req       (arb_req),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  for (genvar i = 0; i < NREQ; i++) begin : g_ctx
    logic              active_q;
    logic [PAGE_W-1:0] page_q;
    logic [CNT_W-1:0]  rem_q;
    logic              cplv_q;
    logic              cple_q;
    logic              accept;
    logic [PAGE_W-1:0] req_pg;
    logic [CNT_W-1:0]  req_n;

    assign req_pg = req_page[i*PAGE_W +: PAGE_W];
    assign req_n  = req_npages[i*CNT_W +: CNT_W];
    assign accept = req_valid[i] & ~active_q;

    // Job context: opened on accept, advanced by engine completions, closed a cycle after its pulse.
    always_ff @(posedge clk) begin
      if (rst) begin
        active_q <= 1'b0;
        page_q   <= '0;
        rem_q    <= '0;
        cplv_q   <= 1'b0;
        cple_q   <= 1'b0;
      end else begin
        cplv_q <= 1'b0;
        cple_q <= 1'b0;
        if (cplv_q) active_q <= 1'b0;
        if (accept) begin
          page_q <= req_pg;
          rem_q  <= req_n;
          if (req_n == '0) cplv_q <= 1'b1;
          else             active_q <= 1'b1;
        end else if (step_oh[i]) begin
          page_q <= page_q + PAGE_W'(1);
          rem_q  <= rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) cplv_q <= 1'b1;
        end else if (abort_oh[i]) begin
          cplv_q <= 1'b1;
          cple_q <= 1'b1;
        end
      end
    end

    assign ctx_active[i] = active_q;
    assign ctx_page[i]   = page_q;
    assign cpl_valid[i]  = cplv_q;
    assign cpl_err[i]    = cple_q;
  end

  // Page scheduler: grant, issue one page, wait for done or watchdog, drain a hung engine.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      sel       <= '0;
      sel_oh    <= '0;
      rr_ptr    <= '0;
      eng_start <= 1'b0;
      eng_page  <= '0;
      wdog      <= '0;
    end else begin
      eng_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            sel    <= grant_idx;
            sel_oh <= grant;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          eng_start <= 1'b1;
          eng_page  <= ctx_page[sel];
          wdog      <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (eng_done) begin
            rr_ptr <= next_ptr;
            state  <= S_IDLE;
          end else if (wdog == TMO_LAST) begin
            state <= S_DRAIN;
          end else begin
            wdog <= wdog + TMO_W'(1);
          end
        end
        S_DRAIN: begin
          if (!eng_busy) begin
            rr_ptr <= next_ptr;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nfc_copy_scheduler.sv
// Self-checking bench for nfc_copy_scheduler: directed table, corner sequences and randomized jobs
// checked against a round-robin job model and a behavioural copy engine.
module tb_nfc_copy_scheduler;

  localparam int NREQ     = 2;
  localparam int PAGE_W   = 9;
  localparam int CNT_W    = 10;
  localparam int TMO_W    = 4;
  localparam int HANG_LEN = 30;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*PAGE_W-1:0] req_page;
  logic [NREQ*CNT_W-1:0]  req_npages;
  logic [NREQ-1:0]        cpl_valid;
  logic [NREQ-1:0]        cpl_err;
  logic                   eng_start;
  logic [PAGE_W-1:0]      eng_page;
  logic                   eng_busy;
  logic                   eng_done;
  logic                   idle;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int eng_delay     = 10;
  bit eng_hang_once = 1'b0;
  bit eng_hang_cur  = 1'b0;
  int eng_cnt       = 0;
  int held_page     = 0;
  int busy_fall_cyc = 0;
  int model_ptr     = 0;

  int obs_page[$];
  int obs_start_cyc[$];
  int obs_cpl_idx[$];
  int obs_cpl_err[$];
  int obs_cpl_cyc[$];
  int exp_page[$];
  int exp_cpl_idx[$];
  int exp_cpl_err[$];

  typedef struct {
    logic [1:0] mask;
    int p0, n0, p1, n1, delay;
    int exp_n, e0, e1, e2, e3;
    int ncpl, c0, c1;
    logic [1:0] ready;
  } vec_t;

  vec_t vecs[4];

  nfc_copy_scheduler #(.NREQ(NREQ), .PAGE_W(PAGE_W), .CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_page   (req_page),
    .req_npages (req_npages),
    .cpl_valid  (cpl_valid),
    .cpl_err    (cpl_err),
    .eng_start  (eng_start),
    .eng_page   (eng_page),
    .eng_busy   (eng_busy),
    .eng_done   (eng_done),
    .idle       (idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Engine: busy from the start pulse for eng_delay cycles, then one done pulse (or silent hang).
  initial begin
    eng_busy = 1'b0;
    eng_done = 1'b0;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (rst) begin
        eng_busy     = 1'b0;
        eng_cnt      = 0;
        eng_hang_cur = 1'b0;
      end else if (eng_start) begin
        eng_busy      = 1'b1;
        held_page     = int'(eng_page);
        eng_hang_cur  = eng_hang_once;
        eng_hang_once = 1'b0;
        eng_cnt       = eng_hang_cur ? HANG_LEN : eng_delay;
      end else if (eng_busy) begin
        if (eng_cnt > 1) begin
          eng_cnt--;
        end else begin
          eng_busy = 1'b0;
          if (eng_hang_cur) begin
            busy_fall_cyc = cyc;
          end else begin
            eng_done = 1'b1;
            checkOutput("eng_page_hold", int'(eng_page), held_page);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (eng_start) begin
        obs_page.push_back(int'(eng_page));
        obs_start_cyc.push_back(cyc);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (cpl_valid[i]) begin
          obs_cpl_idx.push_back(i);
          obs_cpl_err.push_back(int'(cpl_err[i]));
          obs_cpl_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  task automatic clearObs();
    obs_page.delete();
    obs_start_cyc.delete();
    obs_cpl_idx.delete();
    obs_cpl_err.delete();
    obs_cpl_cyc.delete();
  endtask

  task automatic doReset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst cpl_valid", int'(cpl_valid), 0);
    checkOutput("rst cpl_err", int'(cpl_err), 0);
    checkOutput("rst eng_start", int'(eng_start), 0);
    checkOutput("rst eng_page", int'(eng_page), 0);
    checkOutput("rst req_ready", int'(req_ready), 3);
    checkOutput("rst idle", int'(idle), 1);
    rst       = 1'b0;
    model_ptr = 0;
  endtask

  task automatic applyStimulus(input logic [1:0] mask, input int p0, input int n0,
                               input int p1, input int n1, output int acc);
    clearObs();
    @(negedge clk);
    req_valid  = mask;
    req_page   = {PAGE_W'(p1), PAGE_W'(p0)};
    req_npages = {CNT_W'(n1), CNT_W'(n0)};
    @(posedge clk);
    #1;
    acc       = cyc;
    req_valid = '0;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (!idle && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_to_idle", int'(idle), 1);
    repeat (2) @(negedge clk);
  endtask

  // Reference: all posted jobs share the engine one page at a time in cyclic order from model_ptr.
  task automatic modelPost(input logic [1:0] mask, input int p0, input int n0, input int p1, input int n1);
    int pg[NREQ];
    int rem[NREQ];
    int s;
    bit found;
    pg[0]  = p0;
    pg[1]  = p1;
    rem[0] = mask[0] ? n0 : 0;
    rem[1] = mask[1] ? n1 : 0;
    if (mask[0] && n0 == 0) begin exp_cpl_idx.push_back(0); exp_cpl_err.push_back(0); end
    if (mask[1] && n1 == 0) begin exp_cpl_idx.push_back(1); exp_cpl_err.push_back(0); end
    forever begin
      found = 1'b0;
      s = 0;
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (model_ptr + k) % NREQ;
        if (!found && rem[j] > 0) begin
          found = 1'b1;
          s = j;
        end
      end
      if (!found) break;
      exp_page.push_back(pg[s]);
      pg[s] = (pg[s] + 1) % 512;
      rem[s]--;
      if (rem[s] == 0) begin
        exp_cpl_idx.push_back(s);
        exp_cpl_err.push_back(0);
      end
      model_ptr = (s + 1) % NREQ;
    end
  endtask

  task automatic compareRun(input string tag, input int acc);
    checkOutput({tag, " starts"}, obs_page.size(), exp_page.size());
    for (int i = 0; i < exp_page.size() && i < obs_page.size(); i++)
      checkOutput($sformatf("%s page%0d", tag, i), obs_page[i], exp_page[i]);
    if (exp_page.size() > 0 && obs_start_cyc.size() > 0)
      checkOutput({tag, " start_latency"}, obs_start_cyc[0] - acc, 2);
    if (exp_page.size() == 0 && obs_cpl_cyc.size() > 0)
      checkOutput({tag, " zero_cpl_latency"}, obs_cpl_cyc[0] - acc, 0);
    checkOutput({tag, " cpls"}, obs_cpl_idx.size(), exp_cpl_idx.size());
    for (int i = 0; i < exp_cpl_idx.size() && i < obs_cpl_idx.size(); i++) begin
      checkOutput($sformatf("%s cpl%0d idx", tag, i), obs_cpl_idx[i], exp_cpl_idx[i]);
      checkOutput($sformatf("%s cpl%0d err", tag, i), obs_cpl_err[i], exp_cpl_err[i]);
    end
    exp_page.delete();
    exp_cpl_idx.delete();
    exp_cpl_err.delete();
  endtask

  task automatic runJob(input string tag, input logic [1:0] mask, input int p0, input int n0,
                        input int p1, input int n1, input logic [1:0] exp_ready);
    int acc;
    applyStimulus(mask, p0, n0, p1, n1, acc);
    @(negedge clk);
    checkOutput({tag, " ready"}, int'(req_ready), int'(exp_ready));
    waitIdle(400);
    compareRun(tag, acc);
  endtask

  initial begin
    int n;
    int ev[4];
    int acc;
    rst        = 1'b1;
    req_valid  = '0;
    req_page   = '0;
    req_npages = '0;

    vecs[0] = '{2'b01, 5, 3, 0, 0, 10, 3, 5, 6, 7, 0, 1, 0, 0, 2'b10};
    vecs[1] = '{2'b11, 0, 2, 100, 2, 6, 4, 0, 100, 1, 101, 2, 0, 1, 2'b00};
    vecs[2] = '{2'b10, 0, 0, 510, 3, 4, 3, 510, 511, 0, 0, 1, 1, 0, 2'b01};
    vecs[3] = '{2'b01, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0, 1, 0, 0, 2'b11};

    for (int v = 0; v < 4; v++) begin
      doReset();
      eng_delay = vecs[v].delay;
      ev = '{vecs[v].e0, vecs[v].e1, vecs[v].e2, vecs[v].e3};
      for (int i = 0; i < vecs[v].exp_n; i++) exp_page.push_back(ev[i]);
      exp_cpl_idx.push_back(vecs[v].c0);
      exp_cpl_err.push_back(0);
      if (vecs[v].ncpl > 1) begin
        exp_cpl_idx.push_back(vecs[v].c1);
        exp_cpl_err.push_back(0);
      end
      runJob($sformatf("vec%0d", v), vecs[v].mask, vecs[v].p0, vecs[v].n0,
             vecs[v].p1, vecs[v].n1, vecs[v].ready);
    end

    // req_ready stays low through the completion pulse and rises the cycle after.
    doReset();
    eng_delay = 3;
    applyStimulus(2'b01, 7, 1, 0, 0, acc);
    n = 0;
    while (!cpl_valid[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_during_cpl", int'(req_ready[0]), 0);
    @(negedge clk);
    checkOutput("ready_after_cpl", int'(req_ready[0]), 1);
    checkOutput("cpl_single_pulse", int'(cpl_valid[0]), 0);
    waitIdle(100);

    // Hung engine: abort after the watchdog, hold off while busy, then serve the queued job.
    doReset();
    eng_hang_once = 1'b1;
    exp_page.push_back(0);
    exp_page.push_back(200);
    exp_cpl_idx.push_back(0); exp_cpl_err.push_back(1);
    exp_cpl_idx.push_back(1); exp_cpl_err.push_back(0);
    runJob("timeout", 2'b11, 0, 1, 200, 1, 2'b00);
    if (obs_cpl_cyc.size() > 0 && obs_start_cyc.size() > 0)
      checkOutput("timeout latency", obs_cpl_cyc[0] - obs_start_cyc[0], 15);
    if (obs_start_cyc.size() > 1)
      checkOutput("drain_hold", int'(obs_start_cyc[1] > busy_fall_cyc), 1);

    // Done arriving on the expiry cycle wins; one cycle later it is ignored.
    doReset();
    eng_delay = 14;
    exp_page.push_back(40);
    exp_cpl_idx.push_back(0); exp_cpl_err.push_back(0);
    runJob("done_vs_expiry", 2'b01, 40, 1, 0, 0, 2'b10);
    doReset();
    eng_delay = 15;
    exp_page.push_back(40);
    exp_cpl_idx.push_back(0); exp_cpl_err.push_back(1);
    runJob("late_done", 2'b01, 40, 1, 0, 0, 2'b10);

    // Reset in the middle of a job drops it silently.
    doReset();
    eng_delay = 10;
    applyStimulus(2'b01, 77, 4, 0, 0, acc);
    n = 0;
    while (!eng_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rst_mid busy", int'(eng_busy), 1);
    repeat (3) @(negedge clk);
    doReset();
    checkOutput("rst_mid no_cpl", obs_cpl_idx.size(), 0);
    modelPost(2'b10, 0, 0, 9, 2);
    runJob("after_rst", 2'b10, 0, 0, 9, 2, 2'b01);

    // Randomized jobs back to back; the model carries the round-robin pointer across them.
    doReset();
    for (int t = 0; t < 30; t++) begin
      logic [1:0] m;
      logic [1:0] rdy;
      int a0, b0, a1, b1;
      m  = 2'($urandom_range(1, 3));
      a0 = int'($urandom_range(0, 511));
      b0 = int'($urandom_range(0, 4));
      a1 = int'($urandom_range(0, 511));
      b1 = int'($urandom_range(0, 4));
      eng_delay = int'($urandom_range(1, 14));
      rdy = 2'b11;
      if (m[0] && b0 > 0) rdy[0] = 1'b0;
      if (m[1] && b1 > 0) rdy[1] = 1'b0;
      modelPost(m, a0, b0, a1, b1);
      runJob($sformatf("rand%0d", t), m, a0, b0, a1, b1, rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
